// File: rtl/lvdc_timing_sequencer.sv
// rtl/lvdc_timing_sequencer.sv - LVDC phase/bit/word timing chain with run/halt/step arbitration
// Optional feature macro: LVDC_STEP_EN (single instruction-cycle step support).
module lvdc_timing_sequencer #(
  parameter int PHASES = 4,
  parameter int BITS   = 14,
  parameter int WORDS  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       halt_req,
  input  logic       step_req,
  output logic [1:0] phase,
  output logic [3:0] bit_time,
  output logic [1:0] word_time,
  output logic [3:0] tp_strobe,
  output logic       word_start,
  output logic       cycle_end,
  output logic       halted,
  output logic       step_ack
);

  localparam logic [1:0] PH_MAX  = 2'(PHASES - 1);
  localparam logic [3:0] BIT_MAX = 4'(BITS - 1);
  localparam logic [1:0] WD_MAX  = 2'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2
  } state_t;

  state_t state;
  logic   active;
  logic   ph_wrap;
  logic   bit_wrap;
  logic   wd_wrap;

  assign active   = (state != ST_HALTED);
  assign ph_wrap  = (phase == PH_MAX);
  assign bit_wrap = (bit_time == BIT_MAX);
  assign wd_wrap  = (word_time == WD_MAX);

  assign cycle_end  = active & ph_wrap & bit_wrap & wd_wrap;
  assign word_start = active & (phase == 2'd0) & (bit_time == 4'd0);
  assign halted     = (state == ST_HALTED);

  // One-hot phase strobes; lanes beyond the configured phase count stay low.
  always_comb begin
    tp_strobe = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tp_strobe[i] = active && (i < PHASES) && (phase == 2'(i));
    end
  end

  // Three-level counter chain; frozen while halted, which only happens at a full wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= 2'd0;
      bit_time  <= 4'd0;
      word_time <= 2'd0;
    end else if (active) begin
      phase <= ph_wrap ? 2'd0 : phase + 2'd1;
      if (ph_wrap) begin
        bit_time <= bit_wrap ? 4'd0 : bit_time + 4'd1;
        if (bit_wrap) begin
          word_time <= wd_wrap ? 2'd0 : word_time + 2'd1;
        end
      end
    end
  end

`ifdef LVDC_STEP_EN
  logic step_prev;
  logic step_edge;

  assign step_edge = step_req & ~step_prev;

  // Run/halt/step state machine; transitions out of RUN/STEP only on the cycle_end clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_HALTED;
      step_prev <= 1'b0;
      step_ack  <= 1'b0;
    end else begin
      step_prev <= step_req;
      step_ack  <= (state == ST_STEP) && cycle_end;
      case (state)
        ST_HALTED: begin
          if (!halt_req) begin
            state <= ST_RUN;
          end else if (step_edge) begin
            state <= ST_STEP;
          end
        end
        ST_RUN: begin
          if (cycle_end && halt_req) begin
            state <= ST_HALTED;
          end
        end
        ST_STEP: begin
          if (cycle_end) begin
            state <= ST_HALTED;
          end
        end
        default: state <= ST_HALTED;
      endcase
    end
  end
`else
  // Without step support step_req has no effect and no step ever completes.
  assign step_ack = step_req & 1'b0;

  // Run/halt state machine; halting is only taken on the cycle_end clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_HALTED;
    end else begin
      case (state)
        ST_HALTED: begin
          if (!halt_req) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (cycle_end && halt_req) begin
            state <= ST_HALTED;
          end
        end
        default: state <= ST_HALTED;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_lvdc_timing_sequencer.sv
// tb/tb_lvdc_timing_sequencer.sv - scoreboard bench for lvdc_timing_sequencer
module tb_lvdc_timing_sequencer;

  localparam int P     = 4;
  localparam int B     = 14;
  localparam int W     = 3;
  localparam int TOTAL = P * B * W;
`ifdef LVDC_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       halt_req;
  logic       step_req;
  logic [1:0] phase;
  logic [3:0] bit_time;
  logic [1:0] word_time;
  logic [3:0] tp_strobe;
  logic       word_start;
  logic       cycle_end;
  logic       halted;
  logic       step_ack;

  lvdc_timing_sequencer #(.PHASES(P), .BITS(B), .WORDS(W)) dut (
    .clk(clk), .rst_n(rst_n), .halt_req(halt_req), .step_req(step_req),
    .phase(phase), .bit_time(bit_time), .word_time(word_time),
    .tp_strobe(tp_strobe), .word_start(word_start), .cycle_end(cycle_end),
    .halted(halted), .step_ack(step_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  // reference model: state 0=halted 1=run 2=step, t = clock index within the cycle
  int m_st, m_t;
  bit m_ack, m_prev;
  int cnt_ws, cnt_ce, cnt_ack, cnt_act;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_vec(input int st, input int t, input bit ack);
    bit act;
    int ph, bt, wd;
    logic [3:0] tp;
    act = (st != 0);
    ph  = t % P;
    bt  = (t / P) % B;
    wd  = t / (P * B);
    tp  = act ? 4'(1 << ph) : 4'b0000;
    return {(st == 0), ack, (act && t == TOTAL - 1), (act && ph == 0 && bt == 0),
            tp, 2'(wd), 4'(bt), 2'(ph)};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {halted, step_ack, cycle_end, word_start, tp_strobe, word_time, bit_time, phase};
  endfunction

  task automatic model_reset();
    m_st = 0; m_t = 0; m_ack = 0; m_prev = 0;
  endtask

  task automatic pop_compare(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_qempty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check_val(tag, 32'(dut_vec()), 32'(e));
    end
  endtask

  // one clock: advance the model at the edge, push its prediction, compare just after
  task automatic step_clk();
    bit act, cend, sedge;
    int ns;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      act   = (m_st != 0);
      cend  = act && (m_t == TOTAL - 1);
      sedge = STEP_EN && step_req && !m_prev;
      ns    = m_st;
      case (m_st)
        0: if (!halt_req) ns = 1; else if (sedge) ns = 2;
        1: if (cend && halt_req) ns = 0;
        default: if (cend) ns = 0;
      endcase
      m_ack  = (m_st == 2) && cend;
      m_prev = step_req;
      if (act) m_t = (m_t + 1) % TOTAL;
      m_st = ns;
    end
    exp_q.push_back(exp_vec(m_st, m_t, m_ack));
    #1;
    pop_compare("outs");
    cnt_ws  += int'(word_start);
    cnt_ce  += int'(cycle_end);
    cnt_ack += int'(step_ack);
    cnt_act += int'(!halted);
  endtask

  task automatic clear_counts();
    cnt_ws = 0; cnt_ce = 0; cnt_ack = 0; cnt_act = 0;
  endtask

  task automatic wait_halted(input string tag);
    int n;
    n = 0;
    while (!halted && n < 400) begin
      step_clk();
      n++;
    end
    check_val(tag, 32'(halted), 1);
  endtask

  initial begin
    int n;
    bit seen;
    rst_n = 1'b0; halt_req = 1'b1; step_req = 1'b0;
    model_reset();
    repeat (3) step_clk();
    rst_n = 1'b1;

    // 1: held halted after reset
    clear_counts();
    repeat (50) step_clk();
    check_val("t1_act", 32'(cnt_act), 0);
    check_val("t1_ws", 32'(cnt_ws), 0);

    // 2: run two full cycles
    halt_req = 1'b0;
    clear_counts();
    repeat (2 * TOTAL) step_clk();
    check_val("t2_ws", 32'(cnt_ws), 6);
    check_val("t2_ce", 32'(cnt_ce), 2);
    check_val("t2_act", 32'(cnt_act), 2 * TOTAL);

    // 3: halt request at clock 10 of a cycle
    for (int i = 0; i < 400; i++) begin
      if (m_st == 1 && m_t == 10) break;
      step_clk();
    end
    halt_req = 1'b1;
    n = 0;
    while (!halted && n < 400) begin
      step_clk();
      n++;
    end
    check_val("t3_lat", 32'(n), 158);
    check_val("t3_cnt", 32'({word_time, bit_time, phase}), 0);

    // 4: step pulse held 3 clocks, second edge during the step
    step_clk();
    clear_counts();
    seen = 1'b0;
    for (int i = 0; i < 250; i++) begin
      step_req = (i < 3) || (i >= 50 && i < 52);
      step_clk();
      if (!halted) seen = 1'b1;
      if (seen && halted) break;
    end
    step_req = 1'b0;
    check_val("t4_act", 32'(cnt_act), STEP_EN ? TOTAL : 0);
    check_val("t4_ack", 32'(cnt_ack), STEP_EN ? 1 : 0);
    clear_counts();
    repeat (20) step_clk();
    check_val("t4_hold", 32'(cnt_act), 0);
    check_val("t4_ack0", 32'(cnt_ack), 0);

    // 4b: halt_req dropped in the middle of a step
    for (int i = 0; i < 250; i++) begin
      step_req = (i < 2);
      if (i == 60) halt_req = 1'b0;
      step_clk();
    end
    step_req = 1'b0;
    halt_req = 1'b1;
    wait_halted("t4b_halt");

    // 5: step edge together with run request
    step_clk();
    step_req = 1'b1; halt_req = 1'b0;
    clear_counts();
    step_clk();
    check_val("t5_run", 32'(halted), 0);
    repeat (200) step_clk();
    check_val("t5_ack", 32'(cnt_ack), 0);
    step_req = 1'b0;
    halt_req = 1'b1;
    wait_halted("t5_halt");

    // 6: asynchronous reset at bit_time 7 during run
    halt_req = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (m_st == 1 && (m_t / P) % B == 7) break;
      step_clk();
    end
    check_val("t6_bit", 32'(bit_time), 7);
    rst_n = 1'b0;
    model_reset();
    exp_q.push_back(exp_vec(0, 0, 1'b0));
    #1;
    pop_compare("t6_rst");
    halt_req = 1'b1;
    repeat (2) step_clk();
    rst_n = 1'b1;
    repeat (5) step_clk();
    check_val("t6_halted", 32'(halted), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lvdc_timing_sequencer.md
Name: lvdc_timing_sequencer

Overview:
- Central timing sequencer for the LVDC simulation.
- Runs off the buffered oscillator clock and divides it into a three-level count: clock phase, bit time and word time. One instruction cycle is a complete count.
- Publishes the counts plus one-hot phase strobes and word/cycle markers to the datapath modules.
- Arbitrates run, halt and single-step requests from the console side, so the computer only stops or starts on instruction-cycle boundaries.

Parameters:
- PHASES, 4: clock phases per bit time; legal 2..4.
- BITS, 14: bit times per word time (13 data bits + parity); legal 2..16.
- WORDS, 3: word times per instruction cycle; legal 1..4.

Ports:
- clk  in  1  buffered oscillator clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- halt_req  in  1  level; 1 requests halt at the next instruction-cycle boundary, 0 requests run.
- step_req  in  1  rising edge requests one instruction cycle while halted.
- phase  out  2  current clock phase, 0..PHASES-1.
- bit_time  out  4  current bit time, 0..BITS-1.
- word_time  out  2  current word time, 0..WORDS-1.
- tp_strobe  out  4  one-hot decode of phase while active; bits at or above PHASES are always 0.
- word_start  out  1  active and phase==0 and bit_time==0.
- cycle_end  out  1  active and phase, bit_time, word_time all at their maximums.
- halted  out  1  state == HALTED.
- step_ack  out  1  one-clock pulse when a step completes.

Behaviour:
- Reset values: state HALTED; phase, bit_time, word_time = 0; all strobes, cycle_end, word_start and step_ack = 0; halted = 1; step edge register = 0.
- "Active" means state is RUN or STEP. All decoded outputs are combinational from registered state and counters, so they have zero added latency.
- Counter chain, advancing every clk edge while active:
  - phase increments; it wraps PHASES-1 -> 0.
  - bit_time increments on the phase wrap and wraps BITS-1 -> 0.
  - word_time increments on the bit wrap and wraps WORDS-1 -> 0.
  - One instruction cycle = PHASES*BITS*WORDS clocks (168 at defaults).
- Counters hold while HALTED. They are always 0/0/0 in HALTED, because halting only happens at a wrap.
- State machine, evaluated each clk edge:
  - HALTED:
    - halt_req==0 -> RUN.
    - else a step_req rising edge (step_req==1 and its registered previous value==0) -> STEP.
    - else stay HALTED.
    - halt_req==0 has priority over a simultaneous step edge.
  - RUN: on the cycle_end clock, halt_req==1 -> HALTED, else stay RUN. halt_req changes mid-cycle have no effect until cycle_end.
  - STEP: on the cycle_end clock -> HALTED with step_ack=1 for exactly the next clock. halt_req deasserting during STEP does not abort; the step completes, then HALTED, then RUN on the following edge.
- Step edges arriving in RUN or STEP are ignored and are not queued.
- The first active clock after leaving HALTED shows phase 0, bit 0, word 0, with word_start=1 and tp_strobe[0]=1.
- Asynchronous rst_n assertion mid-cycle returns immediately to the reset values. There is no partial-cycle resume.

Optional Feature:
- LVDC_STEP_EN
- Defined: STEP state, step_req edge detection and step_ack exist as described.
- Undefined: step_req is ignored, step_ack is tied 0, and the state machine has only HALTED and RUN.

Test Plan:
1. Reset release with halt_req=1 for 50 clocks -> halted=1, counters 0/0/0, tp_strobe=0000, no word_start.
2. halt_req 1->0 -> RUN on next edge. word_start pulses every 56 clocks. cycle_end pulses every 168 clocks, coincident with phase=3, bit_time=13, word_time=2. tp_strobe cycles 0001,0010,0100,1000.
3. halt_req=1 asserted at clock 10 of a cycle -> counting continues to cycle_end (clock 167). halted=1 on the next edge, with counters at 0/0/0.
4. LVDC_STEP_EN defined, HALTED, step_req pulsed high for 3 clocks -> exactly 168 active clocks, step_ack high for 1 clock, halted=1. A second edge during the step is ignored.
5. Step edge and halt_req 1->0 on the same clock in HALTED -> RUN, no step_ack ever.
6. rst_n pulsed low at bit_time=7 during RUN -> outputs immediately at reset values, halted=1.
